// File: rtl/alu_muldiv_seq.sv
// Sequential 32-bit unsigned multiply / divide that borrows the shared ALU (add/sub) once per cycle.
// 33-cycle latency from accepted start to done; divide-by-zero completes in one cycle.
module alu_muldiv_seq #(
  parameter logic [31:0] DIVZ_QUO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        busy,
  output logic        done,
  output logic [31:0] result_lo,
  output logic [31:0] result_hi,
  output logic        div_zero,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_out
);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state_q;
  logic [5:0]  cnt_q;
  logic [31:0] hi_q, lo_q, mcand_q;
  logic [31:0] res_lo_q, res_hi_q;
  logic        busy_q, done_q, divz_q;

  logic [31:0] hi_d, lo_d, sh;
  logic        carry, ge;

  // hi/lo hold {hi, lo} while multiplying and {rem, quo} while dividing
  always_comb begin
    alu_a  = 32'd0;
    alu_b  = 32'd0;
    alu_op = 3'b000;
    sh     = {hi_q[30:0], lo_q[31]};
    carry  = 1'b0;
    ge     = 1'b0;
    hi_d   = hi_q;
    lo_d   = lo_q;
    case (state_q)
      MUL: begin
        alu_a = hi_q;
        alu_b = lo_q[0] ? mcand_q : 32'd0;
        carry = (alu_out < hi_q);
        hi_d  = {carry, alu_out[31:1]};
        lo_d  = {alu_out[0], lo_q[31:1]};
      end
      DIV: begin
        alu_op = 3'b001;
        alu_a  = sh;
        alu_b  = mcand_q;
        // rem[31] set means the 33-bit shifted remainder already exceeds any divisor
        ge     = hi_q[31] | (sh >= mcand_q);
        hi_d   = ge ? alu_out : sh;
        lo_d   = {lo_q[30:0], ge};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 6'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      mcand_q  <= 32'd0;
      res_lo_q <= 32'd0;
      res_hi_q <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      divz_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
          if (start) begin
            res_lo_q <= 32'd0;
            res_hi_q <= 32'd0;
            divz_q   <= 1'b0;
            cnt_q    <= 6'd0;
            hi_q     <= 32'd0;
            if (!op) begin
              state_q <= MUL;
              busy_q  <= 1'b1;
              lo_q    <= opb;
              mcand_q <= opa;
            end else if (opb != 32'd0) begin
              state_q <= DIV;
              busy_q  <= 1'b1;
              lo_q    <= opa;
              mcand_q <= opb;
            end else begin
              state_q  <= DONE;
              done_q   <= 1'b1;
              res_lo_q <= DIVZ_QUO;
              res_hi_q <= opa;
              divz_q   <= 1'b1;
            end
          end
        end
        default: begin
          hi_q  <= hi_d;
          lo_q  <= lo_d;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            state_q  <= DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            res_lo_q <= lo_d;
            res_hi_q <= hi_d;
          end
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign div_zero  = divz_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq with a behavioural add/sub ALU attached.
module tb_alu_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst, start, op;
  logic [31:0] opa, opb;
  logic        busy, done, div_zero;
  logic [31:0] result_lo, result_hi, alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign alu_out = (alu_op == 3'b001) ? (alu_a - alu_b) : (alu_a + alu_b);

  alu_muldiv_seq dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .result_lo(result_lo), .result_hi(result_hi),
    .div_zero(div_zero), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_out(alu_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the cycle after the accepting edge.
  task automatic start_op(input logic o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1; op = o; opa = a; opb = b;
    @(negedge clk);
    start = 1'b0; opa = 32'hDEAD_BEEF; opb = 32'h1234_5678;
  endtask

  // n0 = cycles since accepting edge already elapsed; returns latency and busy stats.
  task automatic wait_done(input int n0, output int lat, output int nbusy, output int bad_op);
    lat = n0; nbusy = 0; bad_op = 0;
    while (!done && lat < 100) begin
      if (busy) nbusy++;
      if (busy && alu_op !== 3'b000 && !dut.state_q[1] && dut.state_q[0]) bad_op++;
      if (result_lo !== 32'd0 || result_hi !== 32'd0) bad_op++;
      @(negedge clk);
      lat++;
    end
  endtask

  int lat, nb, bo, seen;

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; opa = 32'd0; opb = 32'd0;
    @(negedge clk); @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_res", {result_hi, result_lo}, 64'd0);
    chk("rst_alu", {alu_a, alu_b, 29'd0, alu_op}, 96'd0);
    rst = 1'b0;
    @(negedge clk);

    // mid-MUL reset, held two cycles
    start_op(1'b0, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_res", {result_hi, result_lo}, 64'd0);
    chk("mrst_aluop", alu_op, 3'b000);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    chk("mrst_no_done", seen, 0);

    // MUL 7x6: latency, busy length, alu_op, results zero while busy
    start_op(1'b0, 32'd7, 32'd6);
    wait_done(1, lat, nb, bo);
    chk("mul7x6_lat", lat, 33);
    chk("mul7x6_busy", nb, 32);
    chk("mul7x6_aluop", bo, 0);
    chk("mul7x6_res", {result_hi, result_lo}, 64'd42);
    chk("mul7x6_dz", div_zero, 0);
    @(negedge clk);
    chk("mul7x6_done_pulse", done, 0);
    chk("mul7x6_hold", {result_hi, result_lo}, 64'd42);

    start_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(1, lat, nb, bo);
    chk("mulmax_lat", lat, 33);
    chk("mulmax_res", {result_hi, result_lo}, 64'hFFFF_FFFE_0000_0001);

    start_op(1'b1, 32'd100, 32'd7);
    wait_done(1, lat, nb, bo);
    chk("div100_7_lat", lat, 33);
    chk("div100_7_busy", nb, 32);
    chk("div100_7_res", {result_hi, result_lo}, {32'd2, 32'd14});
    chk("div100_7_dz", div_zero, 0);

    start_op(1'b1, 32'h8000_0001, 32'h8000_0000);
    wait_done(1, lat, nb, bo);
    chk("div_hibit_res", {result_hi, result_lo}, {32'd1, 32'd1});

    start_op(1'b1, 32'hFFFF_FFFF, 32'd1);
    wait_done(1, lat, nb, bo);
    chk("div_by1_res", {result_hi, result_lo}, {32'd0, 32'hFFFF_FFFF});

    // divide by zero
    @(negedge clk);
    start_op(1'b1, 32'd55, 32'd0);
    wait_done(1, lat, nb, bo);
    chk("divz_lat", lat, 1);
    chk("divz_busy", nb, 0);
    chk("divz_busy_now", busy, 0);
    chk("divz_res", {result_hi, result_lo}, {32'd55, 32'hFFFF_FFFF});
    chk("divz_flag", div_zero, 1);
    @(negedge clk);
    chk("divz_flag_held", div_zero, 1);
    chk("divz_res_held", {result_hi, result_lo}, {32'd55, 32'hFFFF_FFFF});

    // start while busy is ignored
    start_op(1'b0, 32'd9, 32'd11);
    chk("divz_flag_clr", div_zero, 0);
    repeat (3) @(negedge clk);
    start_op(1'b1, 32'd1000, 32'd3);
    wait_done(5, lat, nb, bo);
    chk("ign_lat", lat, 33);
    chk("ign_res", {result_hi, result_lo}, 64'd99);

    // back-to-back: start asserted during the DONE cycle
    start_op(1'b1, 32'd1000, 32'd3);
    chk("b2b_busy", busy, 1);
    wait_done(1, lat, nb, bo);
    chk("b2b_lat", lat, 33);
    chk("b2b_res", {result_hi, result_lo}, {32'd1, 32'd333});

    // start and rst together: rst wins
    @(negedge clk);
    rst = 1'b1; start = 1'b1; op = 1'b0; opa = 32'd3; opb = 32'd4;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    chk("rst_start_busy", busy, 0);
    chk("rst_start_res", {result_hi, result_lo}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
